// File: rtl/banner_writer.sv
// banner_writer: fills clipped rectangles in the 1-bit row-major banner RAM, one write per clock.
// Optional feature macro: BANNER_WRITER_PATTERN_EN (cmd_pat selects an 8x8 checker fill).
module banner_writer #(
    parameter int IMG_W = 1440,
    parameter int IMG_H = 100,
    parameter int AW    = 18
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [10:0]   cmd_x0,
    input  logic [10:0]   cmd_y0,
    input  logic [10:0]   cmd_w,
    input  logic [10:0]   cmd_h,
    input  logic          cmd_bit,
    input  logic          cmd_pat,
    output logic          wr_en,
    output logic [AW-1:0] wr_addr,
    output logic          wr_data,
    output logic          busy,
    output logic          done
);

    localparam logic [11:0]   W12  = 12'(IMG_W);
    localparam logic [11:0]   H12  = 12'(IMG_H);
    localparam logic [AW-1:0] W_AW = AW'(IMG_W);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t        state_r;
    state_t        state_s;

    logic [10:0]   x0_r;
    logic [10:0]   y0_r;
    logic [10:0]   w_r;
    logic [10:0]   h_r;
    logic          bit_r;
    logic [11:0]   xe_r;
    logic [11:0]   ye_r;
    logic [10:0]   x_r;
    logic [10:0]   y_r;
    logic [AW-1:0] row_base_r;

    logic          cmd_ready_r;
    logic          wr_en_r;
    logic [AW-1:0] wr_addr_r;
    logic          wr_data_r;
    logic          busy_r;
    logic          done_r;

    logic          cmd_ready_s;
    logic          wr_en_s;
    logic [AW-1:0] wr_addr_s;
    logic          wr_data_s;
    logic          busy_s;
    logic          done_s;

    logic          accept_s;
    logic [11:0]   sum_x_s;
    logic [11:0]   sum_y_s;
    logic [11:0]   xe_s;
    logic [11:0]   ye_s;
    logic          empty_s;
    logic          row_end_s;
    logic          last_s;
    logic          pix_s;

    assign accept_s = cmd_valid & cmd_ready_r;

    // Clip window and empty-rectangle detection from the captured command (12-bit sums never wrap)
    always_comb begin
        sum_x_s = {1'b0, x0_r} + {1'b0, w_r};
        sum_y_s = {1'b0, y0_r} + {1'b0, h_r};
        if (sum_x_s > W12) begin
            xe_s = W12;
        end else begin
            xe_s = sum_x_s;
        end
        if (sum_y_s > H12) begin
            ye_s = H12;
        end else begin
            ye_s = sum_y_s;
        end
        empty_s = ({1'b0, x0_r} >= W12) | ({1'b0, y0_r} >= H12) |
                  (w_r == 11'd0) | (h_r == 11'd0);
    end

    // Scan position tests against the clipped right/bottom edges
    always_comb begin
        row_end_s = (({1'b0, x_r} + 12'd1) == xe_r);
        last_s    = row_end_s & (({1'b0, y_r} + 12'd1) == ye_r);
    end

`ifdef BANNER_WRITER_PATTERN_EN
    logic pat_r;

    function automatic logic fill_bit(input logic b, input logic p,
                                      input logic [10:0] x, input logic [10:0] y);
        if (p) begin
            return b ^ x[3] ^ y[3];
        end else begin
            return b;
        end
    endfunction

    // Pattern select is captured alongside the other command fields
    always_ff @(posedge clk) begin
        if (rst) begin
            pat_r <= 1'b0;
        end else if (accept_s) begin
            pat_r <= cmd_pat;
        end else begin
            pat_r <= pat_r;
        end
    end

    // Checker fill uses absolute pixel coordinates
    always_comb begin
        pix_s = fill_bit(bit_r, pat_r, x_r, y_r);
    end
`else
    logic unused_pat_s;
    assign unused_pat_s = cmd_pat;

    // Plain fill: every pixel takes the command bit
    always_comb begin
        pix_s = bit_r;
    end
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state logic
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    state_s = SETUP;
                end else begin
                    state_s = IDLE;
                end
            end
            SETUP: begin
                if (empty_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            WRITE: begin
                if (last_s) begin
                    state_s = DONE;
                end else begin
                    state_s = WRITE;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // Next values of the registered outputs; they trail the FSM by one cycle
    always_comb begin
        cmd_ready_s = (state_r == IDLE) & ~accept_s;
        busy_s      = accept_s | (state_r != IDLE);
        done_s      = (state_r == DONE);
        if (state_r == WRITE) begin
            wr_en_s   = 1'b1;
            wr_addr_s = row_base_r + AW'(x_r);
            wr_data_s = pix_s;
        end else begin
            wr_en_s   = 1'b0;
            wr_addr_s = '0;
            wr_data_s = 1'b0;
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_ready_r <= 1'b1;
            wr_en_r     <= 1'b0;
            wr_addr_r   <= '0;
            wr_data_r   <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
        end else begin
            cmd_ready_r <= cmd_ready_s;
            wr_en_r     <= wr_en_s;
            wr_addr_r   <= wr_addr_s;
            wr_data_r   <= wr_data_s;
            busy_r      <= busy_s;
            done_r      <= done_s;
        end
    end

    // Command capture and scan datapath; the row base steps by IMG_W instead of multiplying per row
    always_ff @(posedge clk) begin
        if (rst) begin
            x0_r       <= 11'd0;
            y0_r       <= 11'd0;
            w_r        <= 11'd0;
            h_r        <= 11'd0;
            bit_r      <= 1'b0;
            xe_r       <= 12'd0;
            ye_r       <= 12'd0;
            x_r        <= 11'd0;
            y_r        <= 11'd0;
            row_base_r <= '0;
        end else if (accept_s) begin
            x0_r  <= cmd_x0;
            y0_r  <= cmd_y0;
            w_r   <= cmd_w;
            h_r   <= cmd_h;
            bit_r <= cmd_bit;
        end else begin
            case (state_r)
                SETUP: begin
                    xe_r       <= xe_s;
                    ye_r       <= ye_s;
                    x_r        <= x0_r;
                    y_r        <= y0_r;
                    row_base_r <= AW'(y0_r) * W_AW;
                end
                WRITE: begin
                    if (row_end_s) begin
                        x_r        <= x0_r;
                        y_r        <= y_r + 11'd1;
                        row_base_r <= row_base_r + W_AW;
                    end else begin
                        x_r        <= x_r + 11'd1;
                    end
                end
                default: begin
                    x_r <= x_r;
                end
            endcase
        end
    end

    assign cmd_ready = cmd_ready_r;
    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign busy      = busy_r;
    assign done      = done_r;

endmodule

// File: tb/tb_banner_writer.sv
// Self-checking bench for banner_writer: directed and random rectangles against a pixel-list model.
module tb_banner_writer;

    localparam int IMG_W = 1440;
    localparam int IMG_H = 100;
    localparam int AW    = 18;

    logic          clk = 1'b0;
    logic          rst;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [10:0]   cmd_x0, cmd_y0, cmd_w, cmd_h;
    logic          cmd_bit, cmd_pat;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic          wr_data;
    logic          busy, done;

    typedef struct packed {
        logic [10:0] x0;
        logic [10:0] y0;
        logic [10:0] w;
        logic [10:0] h;
        logic        b;
        logic        p;
    } cmd_t;

    cmd_t        cmd_q[$];
    logic [31:0] exp_addr[$];
    logic        exp_data[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    banner_writer #(.IMG_W(IMG_W), .IMG_H(IMG_H), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_x0(cmd_x0), .cmd_y0(cmd_y0), .cmd_w(cmd_w), .cmd_h(cmd_h),
        .cmd_bit(cmd_bit), .cmd_pat(cmd_pat),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Reference: enumerate the clipped pixels row by row
    task automatic build_exp(input cmd_t c);
        int xe, ye;
        logic d;
        exp_addr.delete();
        exp_data.delete();
        xe = int'(c.x0) + int'(c.w);
        ye = int'(c.y0) + int'(c.h);
        if (xe > IMG_W) xe = IMG_W;
        if (ye > IMG_H) ye = IMG_H;
        for (int y = int'(c.y0); y < ye; y++) begin
            for (int x = int'(c.x0); x < xe; x++) begin
`ifdef BANNER_WRITER_PATTERN_EN
                d = c.p ? (c.b ^ 1'((x / 8) % 2) ^ 1'((y / 8) % 2)) : c.b;
`else
                d = c.b;
`endif
                exp_addr.push_back(32'(y * IMG_W + x));
                exp_data.push_back(d);
            end
        end
    endtask

    task automatic drive(input cmd_t c);
        cmd_x0  = c.x0;
        cmd_y0  = c.y0;
        cmd_w   = c.w;
        cmd_h   = c.h;
        cmd_bit = c.b;
        cmd_pat = c.p;
    endtask

    // Issue the head of cmd_q (called at a falling edge) and check every cycle until ready returns
    task automatic run_next(input bit hold);
        cmd_t c;
        int   n, wait_cyc;
        c = cmd_q.pop_front();
        build_exp(c);
        n = exp_addr.size();
        drive(c);
        cmd_valid = 1'b1;
        wait_cyc = 0;
        while (cmd_ready !== 1'b1 && wait_cyc < 50) begin
            @(negedge clk);
            wait_cyc++;
        end
        chk("accept_ready", 32'(cmd_ready), 32'd1);
        if (cmd_ready !== 1'b1) begin
            cmd_valid = 1'b0;
            return;
        end
        chk("accept_wait", 32'(wait_cyc), 32'd0);
        @(posedge clk);
        for (int k = 0; k <= n + 3; k++) begin
            @(negedge clk);
            chk($sformatf("wr_en@%0d", k), 32'(wr_en), 32'(k >= 2 && k < n + 2));
            if (k >= 2 && k < n + 2) begin
                chk($sformatf("wr_addr[%0d]", k - 2), 32'(wr_addr), exp_addr[k - 2]);
                chk($sformatf("wr_data[%0d]", k - 2), 32'(wr_data), 32'(exp_data[k - 2]));
            end
            chk($sformatf("done@%0d", k), 32'(done), 32'(k == n + 2));
            chk($sformatf("busy@%0d", k), 32'(busy), 32'(k <= n + 2));
            chk($sformatf("cmd_ready@%0d", k), 32'(cmd_ready), 32'(k >= n + 3));
            if (k == 0) begin
                if (hold && cmd_q.size() > 0) begin
                    drive(cmd_q[0]);
                end else begin
                    cmd_valid = 1'b0;
                end
            end
        end
    endtask

    initial begin
        cmd_t c;
        rst = 1'b1;
        cmd_valid = 1'b0;
        drive(cmd_t'(0));
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(cmd_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data", 32'(wr_data), 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // Reset in the middle of a long fill
        drive('{x0: 11'd0, y0: 11'd0, w: 11'd100, h: 11'd10, b: 1'b1, p: 1'b0});
        cmd_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("midrst_writing", 32'(wr_en), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_ready", 32'(cmd_ready), 32'd1);
        chk("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("postrst_wr_en", 32'(wr_en), 32'd0);
            chk("postrst_busy", 32'(busy), 32'd0);
        end

        // Directed rectangles: basic, clipped, empty, out of range, checker
        cmd_q.push_back('{x0: 11'd10,   y0: 11'd2,  w: 11'd3, h: 11'd2, b: 1'b1, p: 1'b0});
        cmd_q.push_back('{x0: 11'd1438, y0: 11'd99, w: 11'd5, h: 11'd5, b: 1'b1, p: 1'b0});
        cmd_q.push_back('{x0: 11'd20,   y0: 11'd5,  w: 11'd0, h: 11'd4, b: 1'b1, p: 1'b0});
        cmd_q.push_back('{x0: 11'd1500, y0: 11'd5,  w: 11'd3, h: 11'd3, b: 1'b1, p: 1'b0});
        cmd_q.push_back('{x0: 11'd6,    y0: 11'd0,  w: 11'd4, h: 11'd1, b: 1'b0, p: 1'b1});
        while (cmd_q.size() > 0) begin
            run_next(1'b0);
            repeat (2) @(negedge clk);
        end

        // Back-to-back with cmd_valid held across the busy window
        cmd_q.push_back('{x0: 11'd100, y0: 11'd40, w: 11'd4, h: 11'd2, b: 1'b1, p: 1'b1});
        cmd_q.push_back('{x0: 11'd7,   y0: 11'd7,  w: 11'd3, h: 11'd3, b: 1'b0, p: 1'b1});
        cmd_q.push_back('{x0: 11'd50,  y0: 11'd3,  w: 11'd0, h: 11'd3, b: 1'b1, p: 1'b0});
        run_next(1'b1);
        run_next(1'b1);
        run_next(1'b0);
        @(negedge clk);

        // Random rectangles, biased towards the right/bottom edges
        for (int i = 0; i < 24; i++) begin
            c.x0 = ($urandom_range(3) == 0) ? 11'(1428 + $urandom_range(30)) : 11'($urandom_range(1439));
            c.y0 = ($urandom_range(3) == 0) ? 11'(96 + $urandom_range(8)) : 11'($urandom_range(99));
            c.w  = 11'($urandom_range(12));
            c.h  = 11'($urandom_range(3));
            c.b  = 1'($urandom_range(1));
            c.p  = 1'($urandom_range(1));
            cmd_q.push_back(c);
        end
        while (cmd_q.size() > 0) begin
            run_next(1'($urandom_range(1)));
        end
        repeat (2) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
